// File: rtl/core_l1d_resp.sv
`default_nettype none
// ============================================================================
// Module   : core_l1d_resp
// Purpose  : Data-side memory responder standing in for an L1D cache. Accepts
//            one byte/half/word load or store at a time, steers byte lanes
//            into a word-organised register array and returns a right-aligned,
//            zero-filled read response after WAIT_CYCLES wait states.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            l1d_req_val/cop/size/addr/wdata - request from the core
//            l1d_req_ack         - request accepted this cycle (else stall)
//            l1d_resp_val/data/err - one-cycle response strobe and payload
//            l1d_busy            - a request is in flight (WAIT or RESP)
// Revision : 1.0 - initial release
// ============================================================================
module core_l1d_resp #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        l1d_req_val,
  input  logic        l1d_req_cop,
  input  logic [2:0]  l1d_req_size,
  input  logic [31:0] l1d_req_addr,
  input  logic [31:0] l1d_req_wdata,
  output logic        l1d_req_ack,
  output logic        l1d_resp_val,
  output logic [31:0] l1d_resp_data,
  output logic        l1d_resp_err,
  output logic        l1d_busy
);

  localparam int         IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_cop;
  logic [2:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [MEM_WORDS];

  // Acceptance is gated by reset so nothing is acknowledged while held in reset.
  assign l1d_req_ack = rst_n && (state == ST_IDLE) && l1d_req_val;
  assign l1d_busy    = (state != ST_IDLE);

  // Operands of the access that commits on the edge into RESP. With zero wait
  // states that edge is the accepting edge itself, so the live request is used.
  logic        op_cop;
  logic [2:0]  op_size;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;

  always_comb begin
    op_cop   = cap_cop;
    op_size  = cap_size;
    op_addr  = cap_addr;
    op_wdata = cap_wdata;
    if (state == ST_IDLE) begin
      op_cop   = l1d_req_cop;
      op_size  = l1d_req_size;
      op_addr  = l1d_req_addr;
      op_wdata = l1d_req_wdata;
    end
  end

  logic go_resp;
  assign go_resp = (l1d_req_ack && (WAIT_CYCLES == 0)) ||
                   ((state == ST_WAIT) && (cnt == 4'd0));

  // Error classification and lane steering
  logic [31:0]      offset;
  logic             size_err;
  logic             op_err;
  logic [31:0]      size_mask;
  logic [IDX_W-1:0] idx;
  logic [4:0]       shift;
  logic [31:0]      old_word;
  logic [31:0]      lane_mask;
  logic [31:0]      rd_data;
  logic [31:0]      wr_word;

  assign offset = op_addr - ADDR_BASE;

  always_comb begin
    size_err  = 1'b1;
    size_mask = 32'h0000_0000;
    case (op_size)
      3'b000: begin size_err = 1'b0;                   size_mask = 32'h0000_00FF; end
      3'b001: begin size_err = op_addr[0];             size_mask = 32'h0000_FFFF; end
      3'b010: begin size_err = (op_addr[1:0] != 2'b0); size_mask = 32'hFFFF_FFFF; end
      default: begin size_err = 1'b1;                  size_mask = 32'h0000_0000; end
    endcase
  end

  assign op_err    = size_err || (op_addr < ADDR_BASE) ||
                     ((offset >> 2) >= 32'(MEM_WORDS));
  assign idx       = offset[IDX_W+1:2];
  // Aligned halves always have addr[0]=0, so the byte shift also serves the half lane.
  assign shift     = {op_addr[1:0], 3'b000};
  assign old_word  = mem[idx];
  assign lane_mask = size_mask << shift;
  assign rd_data   = (old_word >> shift) & size_mask;
  assign wr_word   = (old_word & ~lane_mask) | ((op_wdata << shift) & lane_mask);

  // Array has no reset; a reset during WAIT leaves the FSM idle so go_resp stays low.
  always_ff @(posedge clk) begin
    if (go_resp && op_cop && !op_err) begin
      mem[idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      cap_cop       <= 1'b0;
      cap_size      <= 3'd0;
      cap_addr      <= 32'd0;
      cap_wdata     <= 32'd0;
      l1d_resp_val  <= 1'b0;
      l1d_resp_data <= 32'd0;
      l1d_resp_err  <= 1'b0;
    end else begin
      l1d_resp_val <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (l1d_req_ack) begin
            cap_cop   <= l1d_req_cop;
            cap_size  <= l1d_req_size;
            cap_addr  <= l1d_req_addr;
            cap_wdata <= l1d_req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (go_resp) begin
        l1d_resp_val  <= 1'b1;
        l1d_resp_data <= (op_cop || op_err) ? 32'd0 : rd_data;
        l1d_resp_err  <= op_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_l1d_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_l1d_resp
// Purpose  : Scoreboard bench for core_l1d_resp. Two instances run side by
//            side (WAIT_CYCLES=2 and WAIT_CYCLES=0). Drivers push expected
//            responses from a byte-level reference model; a monitor pops and
//            compares data, error flag, response cycle and busy each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_l1d_resp;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_val   [2];
  logic        req_cop   [2];
  logic [2:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        ack       [2];
  logic        resp_val  [2];
  logic [31:0] resp_data [2];
  logic        resp_err  [2];
  logic        busy      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    core_l1d_resp #(
      .MEM_WORDS  (MEM_WORDS),
      .WAIT_CYCLES((g == 0) ? 2 : 0),
      .ADDR_BASE  (32'h0000_0000)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .l1d_req_val  (req_val[g]),
      .l1d_req_cop  (req_cop[g]),
      .l1d_req_size (req_size[g]),
      .l1d_req_addr (req_addr[g]),
      .l1d_req_wdata(req_wdata[g]),
      .l1d_req_ack  (ack[g]),
      .l1d_resp_val (resp_val[g]),
      .l1d_resp_data(resp_data[g]),
      .l1d_resp_err (resp_err[g]),
      .l1d_busy     (busy[g])
    );
  end

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] mm [2][MEM_WORDS];

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int qn(input int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qf(input int d);
    if (d == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void qdrop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void chk(input string name, input int d,
                              input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endfunction

  // Reference model: byte-by-byte view of the access rules.
  function automatic void model(input int d, input logic cop, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] data, output logic err);
    int nb;
    int unsigned wi, lane;
    data = 32'd0;
    case (size)
      3'd0:    nb = 1;
      3'd1:    nb = 2;
      3'd2:    nb = 4;
      default: nb = 0;
    endcase
    err = (nb == 0);
    if (!err && ((addr % 32'(nb)) != 0)) err = 1'b1;
    if ((addr / 4) >= MEM_WORDS) err = 1'b1;
    if (err) return;
    wi = addr / 4;
    for (int k = 0; k < nb; k++) begin
      lane = (addr % 4) + k;
      if (cop) mm[d][wi][8*lane +: 8] = wdata[8*k +: 8];
      else     data[8*k +: 8] = mm[d][wi][8*lane +: 8];
    end
  endfunction

  task automatic issue(input int d, input logic cop, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit expect_resp, output int acc);
    int n;
    exp_t e;
    req_cop[d]   = cop;
    req_size[d]  = size;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_val[d]   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[d] && n < 64);
    tests++;
    if (!ack[d]) begin
      failed++;
      $display("FAIL ack_timeout dut%0d: got no ack after %0d cycles, expected ack", d, n);
      req_val[d] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (expect_resp) begin
      model(d, cop, size, addr, wdata, e.data, e.err);
      e.acc = cyc;
      e.due = cyc + wc(d) + 1;
      qpush(d, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int n);
    req_val[d] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input int d);
    chk("rst_resp_val",  d, {31'd0, resp_val[d]}, 32'd0);
    chk("rst_resp_data", d, resp_data[d], 32'd0);
    chk("rst_resp_err",  d, {31'd0, resp_err[d]}, 32'd0);
    chk("rst_busy",      d, {31'd0, busy[d]}, 32'd0);
    chk("rst_ack",       d, {31'd0, ack[d]}, 32'd0);
  endtask

  task automatic preload(input int d);
    int a;
    for (int w = 0; w < 32; w++) begin
      logic [31:0] v;
      v = $urandom;
      if (w == 12) v = 32'd0;
      issue(d, 1'b1, 3'd2, 32'(w * 4), v, 1'b1, a);
    end
    idle(d, 1);
  endtask

  task automatic b2b(input int d);
    int a, a_prev;
    a_prev = 0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) issue(d, 1'b1, 3'd2, 32'(32'h40 + 4 * i), $urandom, 1'b1, a);
      else            issue(d, 1'b0, 3'd2, 32'(32'h40 + 4 * (i - 1)), 32'd0, 1'b1, a);
      if (i > 0) chk("ack_spacing", d, 32'(a - a_prev), 32'(wc(d) + 2));
      a_prev = a;
    end
    idle(d, 2);
  endtask

  task automatic rnd(input int d, input int n);
    int a;
    logic [2:0]  sz;
    logic [31:0] ad;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom % 16;
      if (r < 5)       sz = 3'd0;
      else if (r < 10) sz = 3'd1;
      else if (r < 14) sz = 3'd2;
      else             sz = 3'($urandom_range(3, 7));
      r = $urandom % 16;
      if (r == 0)      ad = 32'h0000_1000 + ($urandom % 32'h100);
      else if (r == 1) ad = 32'hFFFF_F000 | ($urandom % 32'h1000);
      else             ad = $urandom % 128;
      issue(d, 1'($urandom % 2), sz, ad, $urandom, 1'b1, a);
      r = $urandom % 3;
      if (r != 0) idle(d, r);
    end
    idle(d, 2);
  endtask

  // Monitor: response payload, response cycle, busy and ack exclusivity.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic exp_busy;
        exp_t e;
        exp_busy = 1'b0;
        if (qn(d) > 0) exp_busy = (cyc > qf(d).acc);
        chk("busy", d, {31'd0, busy[d]}, {31'd0, exp_busy});
        chk("ack_while_busy", d, {31'd0, ack[d] & busy[d]}, 32'd0);
        if (resp_val[d]) begin
          if (qn(d) == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_resp dut%0d cyc=%0d: got resp_val=1 expected 0", d, cyc);
          end else begin
            e = qf(d);
            qdrop(d);
            chk("resp_data",  d, resp_data[d], e.data);
            chk("resp_err",   d, {31'd0, resp_err[d]}, {31'd0, e.err});
            chk("resp_cycle", d, 32'(cyc), 32'(e.due));
          end
        end else if (qn(d) > 0) begin
          e = qf(d);
          if (cyc >= e.due) begin
            tests++;
            failed++;
            $display("FAIL missing_resp dut%0d cyc=%0d: got resp_val=0 expected 1 at cyc %0d",
                     d, cyc, e.due);
            qdrop(d);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    for (int d = 0; d < 2; d++) begin
      req_val[d] = 1'b1;
      req_cop[d] = 1'b0;
      req_size[d] = 3'd2;
      req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0;
    end
    // Reset state, including ack held low against a pending req_val.
    repeat (2) @(negedge clk);
    check_quiet(0);
    check_quiet(1);
    @(posedge clk);
    #1;
    req_val[0] = 1'b0;
    req_val[1] = 1'b0;
    rst_n = 1'b1;
    idle(0, 2);

    fork
      preload(0);
      preload(1);
    join

    // Word write then read
    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1, a);
    issue(0, 1'b0, 3'd2, 32'h10, 32'd0, 1'b1, a);
    // Byte lane write and reads (upper wdata bits must be ignored)
    issue(0, 1'b1, 3'd2, 32'h20, 32'h1122_3344, 1'b1, a);
    issue(0, 1'b1, 3'd0, 32'h23, 32'hFFFF_FFAA, 1'b1, a);
    issue(0, 1'b0, 3'd2, 32'h20, 32'd0, 1'b1, a);
    issue(0, 1'b0, 3'd0, 32'h23, 32'd0, 1'b1, a);
    idle(0, 1);
    // Misaligned and reserved accesses, then confirm the word is untouched
    issue(0, 1'b1, 3'd1, 32'h21, 32'h5555_5555, 1'b1, a);
    issue(0, 1'b0, 3'd2, 32'h22, 32'd0, 1'b1, a);
    issue(0, 1'b1, 3'd7, 32'h20, 32'h6666_6666, 1'b1, a);
    issue(0, 1'b0, 3'd2, 32'h20, 32'd0, 1'b1, a);
    // Out-of-range write/read must not alias onto word 0
    issue(0, 1'b1, 3'd2, 32'h1000, 32'hCAFE_F00D, 1'b1, a);
    issue(0, 1'b0, 3'd2, 32'h1000, 32'd0, 1'b1, a);
    issue(0, 1'b0, 3'd2, 32'h0, 32'd0, 1'b1, a);
    idle(0, 2);

    // Back-to-back with req_val held high
    b2b(0);
    b2b(1);

    // Reset during WAIT discards the pending write
    issue(0, 1'b0, 3'd2, 32'h10, 32'd0, 1'b1, a);
    idle(0, 3);
    issue(0, 1'b1, 3'd2, 32'h30, 32'h1234_5678, 1'b0, a);
    rst_n = 1'b0;
    @(negedge clk);
    check_quiet(0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_quiet(0);
    check_quiet(1);
    @(posedge clk);
    #1;
    req_val[0] = 1'b0;
    rst_n = 1'b1;
    idle(0, 1);
    issue(0, 1'b0, 3'd2, 32'h30, 32'd0, 1'b1, a);
    issue(0, 1'b0, 3'd2, 32'h10, 32'd0, 1'b1, a);
    idle(0, 2);

    // Randomized traffic on both instances
    fork
      rnd(0, 150);
      rnd(1, 150);
    join

    idle(0, 6);
    chk("queue_empty", 0, 32'(qn(0)), 32'd0);
    chk("queue_empty", 1, 32'(qn(1)), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
